// File: rtl/global_avg_pool.sv
// global_avg_pool: per-channel sum over all spatial positions, reciprocal-scaled and streamed out one lane group per beat
module global_avg_pool #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPS_PER_CYCLE = 10,
  parameter int CHANNELS      = 1024,
  parameter int SPATIAL       = 49,
  parameter int ACC_WIDTH     = 16,
  parameter int RECIP         = 1337,
  parameter int SHIFT         = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   operands,
  output logic                                  data_valid,
  input  logic                                  out_ready,
  output logic                                  done
);
  localparam int GROUPS = (CHANNELS + OPS_PER_CYCLE - 1) / OPS_PER_CYCLE;
  localparam int GW     = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam int PW     = SPATIAL > 1 ? $clog2(SPATIAL) : 1;
  localparam int OW     = OPS_PER_CYCLE * DATA_WIDTH;
  localparam int PRW    = ACC_WIDTH + SHIFT;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t               state_q, state_d;
  logic [GW-1:0]        grp_q, grp_d, sel;
  logic [PW-1:0]        pos_q, pos_d;
  logic [OW-1:0]        ops_q, ops_d, scaled;
  logic                 dv_q, dv_d, done_q;
  logic                 beat, last_grp, last_pos;
  logic [ACC_WIDTH-1:0] acc_q [GROUPS][OPS_PER_CYCLE];
  assign beat       = state_q == ACCUM && in_valid;
  assign last_grp   = grp_q == GW'(GROUPS - 1);
  assign last_pos   = pos_q == PW'(SPATIAL - 1);
  assign in_ready   = state_q == ACCUM;
  assign operands   = ops_q;
  assign data_valid = dv_q;
  assign done       = done_q;
  // While a group is on the output, the scaler already looks at the next one
  assign sel = (dv_q && !last_grp) ? grp_q + 1'b1 : grp_q;
  for (genvar k = 0; k < OPS_PER_CYCLE; k++) begin : g_lane
    logic [PRW-1:0] prod, quo;
    assign prod = PRW'(acc_q[sel][k]) * PRW'(RECIP) + PRW'(2 ** (SHIFT - 1));
    assign quo  = prod >> SHIFT;
    assign scaled[k*DATA_WIDTH +: DATA_WIDTH] =
      (int'(sel) * OPS_PER_CYCLE + k >= CHANNELS) ? '0 :
      (quo > PRW'(2 ** DATA_WIDTH - 1))           ? {DATA_WIDTH{1'b1}} : quo[DATA_WIDTH-1:0];
  end
  // The pos==0 write doubles as the clear, so the array needs no reset
  always_ff @(posedge clock) begin
    if (beat)
      for (int k = 0; k < OPS_PER_CYCLE; k++)
        acc_q[grp_q][k] <= (pos_q == '0 ? '0 : acc_q[grp_q][k]) + ACC_WIDTH'(in_data[k*DATA_WIDTH +: DATA_WIDTH]);
  end
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    pos_d   = pos_q;
    ops_d   = ops_q;
    dv_d    = dv_q;
    case (state_q)
      IDLE:  state_d = start ? ACCUM : IDLE;
      ACCUM: if (in_valid) begin
        grp_d   = last_grp ? '0 : grp_q + 1'b1;
        pos_d   = !last_grp ? pos_q : last_pos ? '0 : pos_q + 1'b1;
        state_d = (last_grp && last_pos) ? DRAIN : ACCUM;
      end
      DRAIN: if (!dv_q) begin
        ops_d = scaled;
        dv_d  = 1'b1;
      end else if (out_ready) begin
        ops_d   = last_grp ? ops_q : scaled;
        dv_d    = !last_grp;
        grp_d   = last_grp ? '0 : grp_q + 1'b1;
        state_d = last_grp ? DONE : DRAIN;
      end
      DONE:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grp_q   <= '0;
      pos_q   <= '0;
      ops_q   <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      pos_q   <= pos_d;
      ops_q   <= ops_d;
      dv_q    <= dv_d;
      done_q  <= state_q == DONE;
    end
  end
endmodule

// File: tb/tb_global_avg_pool.sv
// tb_global_avg_pool: randomized frames checked by a queue scoreboard against a per-channel sum/average model
module tb_global_avg_pool;
  localparam int DW = 8, OPS = 10, CH = 1024, SP = 49, GR = 103, RECIP = 1337;
  localparam int S_CH = 20, S_SP = 4, S_GR = 2, S_RECIP = 16384;
  logic clock = 0, reset = 1, start = 0, in_valid = 0, out_ready = 1;
  logic in_ready, data_valid, done;
  logic [OPS*DW-1:0] in_data = '0, operands;
  logic s_start = 0, s_valid = 0, s_ready, s_dv, s_done;
  logic [OPS*DW-1:0] s_data = '0, s_ops;
  always #5 clock = ~clock;
  global_avg_pool dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .operands(operands), .data_valid(data_valid), .out_ready(out_ready), .done(done));
  global_avg_pool #(.CHANNELS(S_CH), .SPATIAL(S_SP), .RECIP(S_RECIP)) dut_s (
    .clock(clock), .reset(reset), .start(s_start), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .operands(s_ops), .data_valid(s_dv), .out_ready(1'b1), .done(s_done));
  int n_cmp = 0, n_bad = 0, n_done = 0, s_n_done = 0, exp_frames = 0;
  logic [OPS*DW-1:0] exp_q[$], s_exp_q[$];
  int sums[CH];
  bit stall = 0;
  int sc = 0;
  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] ref_avg(input longint sum, input longint recip);
    longint a = (sum * recip + 32768) >> 16;
    return a > 255 ? 8'd255 : a[7:0];
  endfunction
  always @(posedge clock) begin
    #2;
    out_ready = !stall || sc == 3;
    sc = (stall && sc != 3) ? sc + 1 : 0;
  end
  logic pv = 0, pr = 0, pd = 0;
  logic [OPS*DW-1:0] pops = '0;
  always @(negedge clock) begin
    if (!reset) begin
      if (pv && !pr) check("stall_hold", {data_valid, operands}, {1'b1, pops});
      if (data_valid && out_ready) begin
        check("vec_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("vec", operands, exp_q.pop_front());
      end
      if (done) begin
        n_done++;
        check("done_after_drain", exp_q.size(), 0);
        check("done_one_cycle", pd, 0);
      end
      if (s_dv) begin
        check("s_vec_pending", s_exp_q.size() > 0, 1);
        if (s_exp_q.size() > 0) check("s_vec", s_ops, s_exp_q.pop_front());
      end
      if (s_done) s_n_done++;
    end
    pv = data_valid && !reset;
    pr = out_ready;
    pops = operands;
    pd = done;
  end
  task automatic drive_frame(input int fill, input bit toggle, input int stop_pos, input int start_at);
    logic [OPS*DW-1:0] v, e;
    int t = 0, b = 0;
    bit ok;
    foreach (sums[c]) sums[c] = 0;
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
    for (int p = 0; p < stop_pos; p++)
      for (int g = 0; g < GR; g++) begin
        for (int k = 0; k < OPS; k++) begin
          v[k*DW +: DW] = (fill < 0 || g*OPS+k >= CH) ? DW'($urandom_range(255)) : DW'(fill);
          if (g*OPS+k < CH) sums[g*OPS+k] += int'(v[k*DW +: DW]);
        end
        in_data = v;
        start = b == start_at;
        ok = 0;
        for (int w = 0; w < 8 && !ok; w++) begin
          in_valid = !toggle || t[0] == 1'b0;
          t++;
          ok = in_valid && in_ready;
          @(negedge clock);
        end
        start = 0;
        b++;
        if (!ok) begin
          $display("FAIL beat_accept: in_ready stuck low at pos %0d grp %0d", p, g);
          $fatal(1);
        end
      end
    in_valid = 0;
    if (stop_pos == SP) begin
      for (int g = 0; g < GR; g++) begin
        for (int k = 0; k < OPS; k++)
          e[k*DW +: DW] = (g*OPS+k < CH) ? ref_avg(sums[g*OPS+k], RECIP) : '0;
        exp_q.push_back(e);
      end
      exp_frames++;
    end
  endtask
  task automatic wait_done();
    int w = 0;
    while (n_done < exp_frames && w < 3000) begin
      @(negedge clock);
      w++;
    end
    check("done_seen", n_done, exp_frames);
    @(negedge clock);
  endtask
  task automatic small_frame();
    logic [OPS*DW-1:0] v, e;
    int ss[S_CH];
    bit ok;
    foreach (ss[c]) ss[c] = 0;
    @(negedge clock) s_start = 1;
    @(negedge clock) s_start = 0;
    for (int p = 0; p < S_SP; p++)
      for (int g = 0; g < S_GR; g++) begin
        for (int k = 0; k < OPS; k++) begin
          v[k*DW +: DW] = (g*OPS+k < S_CH) ? DW'(g*OPS+k+p) : DW'($urandom_range(255));
          if (g*OPS+k < S_CH) ss[g*OPS+k] += g*OPS+k+p;
        end
        s_data = v;
        s_valid = 1;
        ok = s_ready;
        @(negedge clock);
        check("s_ready", ok, 1);
      end
    s_valid = 0;
    for (int g = 0; g < S_GR; g++) begin
      for (int k = 0; k < OPS; k++)
        e[k*DW +: DW] = (g*OPS+k < S_CH) ? ref_avg(ss[g*OPS+k], S_RECIP) : '0;
      s_exp_q.push_back(e);
    end
  endtask
  initial begin
    int w;
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_done", done, 0);
    check("rst_operands", operands, 0);
    reset = 0;
    small_frame();
    drive_frame(255, 0, SP, -1);
    wait_done();
    stall = 1;
    drive_frame(-1, 1, SP, -1);
    wait_done();
    stall = 0;
    drive_frame(-1, 0, 10, -1);
    #2 reset = 1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_outputs", {data_valid, done, operands}, 0);
    @(negedge clock) reset = 0;
    check("no_done_partial", n_done, exp_frames);
    drive_frame(7, 0, SP, -1);
    wait_done();
    drive_frame(-1, 0, SP, 1500);
    w = 0;
    while (!data_valid && w < 100) begin @(negedge clock); w++; end
    while (data_valid && w < 3000) begin @(negedge clock); w++; end
    start = 1;
    @(negedge clock) start = 0;
    repeat (5) @(negedge clock);
    check("start_in_done_ignored", in_ready, 0);
    wait_done();
    drive_frame(200, 0, SP, -1);
    wait_done();
    drive_frame(3, 0, SP, -1);
    wait_done();
    repeat (10) @(negedge clock);
    check("exp_q_empty", exp_q.size(), 0);
    check("s_exp_q_empty", s_exp_q.size(), 0);
    check("done_count", n_done, exp_frames);
    check("s_done_count", s_n_done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
